// File: rtl/cache_wb_controller_if.sv
// Memory-arbiter beat channel of the write-back cache controller.
// The controller uses the master side; the arbiter (or a bench model) uses the slave side.
interface cache_wb_controller_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  mm_req;
    logic                  mm_we;
    logic [ADDR_WIDTH-3:0] mm_addr;
    logic                  mm_ack;

    modport master (output mm_req, output mm_we, output mm_addr, input mm_ack);
    modport slave  (input mm_req, input mm_we, input mm_addr, output mm_ack);
endinterface

// File: rtl/cache_wb_controller.sv
// Write-back data-cache miss sequencer: optional victim write-back, line refill, tag/MESI commit.
// Optional macro CACHE_STATS_EN adds saturating hit/miss/write-back counters.
module cache_wb_controller #(
    parameter int ADDR_WIDTH      = 14,
    parameter int TAG_BITS        = 5,
    parameter int INDEX_BITS      = 3,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int CACHE_WAY       = 8,
    localparam int OFF            = $clog2(WORDS_PER_BLOCK)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rd,
    input  logic                  i_wr,
    input  logic                  i_hit,
    input  logic [TAG_BITS-1:0]   i_victim_tag,
    input  logic [1:0]            i_victim_mesi,
    output logic [TAG_BITS-1:0]   o_tag,
    output logic [INDEX_BITS-1:0] o_index,
    output logic [OFF-1:0]        o_offset,
    output logic                  o_stall,
    output logic                  o_modify,
    cache_wb_controller_if.master mm,
    output logic                  o_evict_rd,
    output logic                  o_refill_we,
    output logic [OFF-1:0]        o_beat,
    output logic                  o_wetag,
    output logic [1:0]            o_set_mesi,
    output logic                  o_done
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           o_hit_cnt,
    output logic [31:0]           o_miss_cnt,
    output logic [31:0]           o_wb_cnt
`endif
);

    localparam int MM_AW = ADDR_WIDTH - 2;
    localparam logic [OFF-1:0] LAST_BEAT = OFF'(WORDS_PER_BLOCK - 1);
    localparam int unusedWays = CACHE_WAY;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVICT,
        S_REFILL,
        S_COMMIT
    } state_e;

    state_e                state_q, state_d;
    logic [OFF-1:0]        beat_q, beat_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [INDEX_BITS-1:0] index_q, index_d;
    logic [OFF-1:0]        offset_q, offset_d;
    logic [TAG_BITS-1:0]   victimTag_q, victimTag_d;
    logic                  isWrite_q, isWrite_d;

    logic                  coreReq;
    logic [TAG_BITS-1:0]   reqTag;
    logic [INDEX_BITS-1:0] reqIndex;
    logic [OFF-1:0]        reqOffset;
    logic                  unusedAddrBits;

    // Byte-select bits and any address bits above the tag never reach the cache fields.
    assign coreReq        = i_rd | i_wr;
    assign reqTag         = i_addr[OFF+2+INDEX_BITS +: TAG_BITS];
    assign reqIndex       = i_addr[OFF+2 +: INDEX_BITS];
    assign reqOffset      = i_addr[2 +: OFF];
    assign unusedAddrBits = ^i_addr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            tag_q       <= '0;
            index_q     <= '0;
            offset_q    <= '0;
            victimTag_q <= '0;
            isWrite_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            tag_q       <= tag_d;
            index_q     <= index_d;
            offset_q    <= offset_d;
            victimTag_q <= victimTag_d;
            isWrite_q   <= isWrite_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        tag_d       = tag_q;
        index_d     = index_q;
        offset_d    = offset_q;
        victimTag_d = victimTag_q;
        isWrite_d   = isWrite_q;

        o_tag       = tag_q;
        o_index     = index_q;
        o_offset    = offset_q;
        o_stall     = 1'b1;
        o_modify    = 1'b0;
        mm.mm_req   = 1'b0;
        mm.mm_we    = 1'b0;
        mm.mm_addr  = '0;
        o_evict_rd  = 1'b0;
        o_refill_we = 1'b0;
        o_wetag     = 1'b0;
        o_set_mesi  = 2'b00;
        o_done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_tag    = reqTag;
                o_index  = reqIndex;
                o_offset = reqOffset;
                o_stall  = coreReq & ~i_hit;
                o_modify = i_wr & i_hit;
                if (coreReq && !i_hit) begin
                    tag_d       = reqTag;
                    index_d     = reqIndex;
                    offset_d    = reqOffset;
                    victimTag_d = i_victim_tag;
                    isWrite_d   = i_wr;
                    beat_d      = '0;
                    state_d     = (i_victim_mesi == 2'b10) ? S_EVICT : S_REFILL;
                end
            end
            S_EVICT: begin
                mm.mm_req  = 1'b1;
                mm.mm_we   = 1'b1;
                o_evict_rd = 1'b1;
                mm.mm_addr = MM_AW'({victimTag_q, index_q, beat_q});
                if (mm.mm_ack) begin
                    beat_d = beat_q + OFF'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                mm.mm_req   = 1'b1;
                mm.mm_addr  = MM_AW'({tag_q, index_q, beat_q});
                o_refill_we = mm.mm_ack;
                if (mm.mm_ack) begin
                    beat_d = beat_q + OFF'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                o_wetag    = 1'b1;
                o_done     = 1'b1;
                o_set_mesi = isWrite_q ? 2'b10 : 2'b11;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_beat = beat_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hitCnt_q, missCnt_q, wbCnt_q;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
            wbCnt_q   <= '0;
        end else begin
            if (state_q == S_IDLE && coreReq && i_hit && hitCnt_q != 32'hFFFF_FFFF) begin
                hitCnt_q <= hitCnt_q + 32'd1;
            end
            if (state_q == S_IDLE && state_d != S_IDLE && missCnt_q != 32'hFFFF_FFFF) begin
                missCnt_q <= missCnt_q + 32'd1;
            end
            if (state_q != S_EVICT && state_d == S_EVICT && wbCnt_q != 32'hFFFF_FFFF) begin
                wbCnt_q <= wbCnt_q + 32'd1;
            end
        end
    end

    assign o_hit_cnt  = hitCnt_q;
    assign o_miss_cnt = missCnt_q;
    assign o_wb_cnt   = wbCnt_q;
`endif

endmodule

// File: tb/tb_cache_wb_controller.sv
// Directed-vector bench for cache_wb_controller with default parameters (4-word lines).
// Each record holds one cycle of inputs plus the hand-computed outputs for that cycle.
module tb_cache_wb_controller;

    logic        clk;
    logic        nrst;
    logic [13:0] iAddr;
    logic        iRd, iWr, iHit;
    logic [4:0]  iVictimTag;
    logic [1:0]  iVictimMesi;
    logic [4:0]  oTag;
    logic [2:0]  oIndex;
    logic [1:0]  oOffset;
    logic        oStall, oModify, oEvictRd, oRefillWe, oWetag, oDone;
    logic [1:0]  oBeat, oSetMesi;
`ifdef CACHE_STATS_EN
    logic [31:0] oHitCnt, oMissCnt, oWbCnt;
`endif

    int checks = 0;
    int fails  = 0;
    int expHit = 0;
    int expMiss = 0;
    int expWb = 0;

    cache_wb_controller_if #(.ADDR_WIDTH(14)) mm ();

    cache_wb_controller dut (
        .clk           (clk),
        .nrst          (nrst),
        .i_addr        (iAddr),
        .i_rd          (iRd),
        .i_wr          (iWr),
        .i_hit         (iHit),
        .i_victim_tag  (iVictimTag),
        .i_victim_mesi (iVictimMesi),
        .o_tag         (oTag),
        .o_index       (oIndex),
        .o_offset      (oOffset),
        .o_stall       (oStall),
        .o_modify      (oModify),
        .mm            (mm),
        .o_evict_rd    (oEvictRd),
        .o_refill_we   (oRefillWe),
        .o_beat        (oBeat),
        .o_wetag       (oWetag),
        .o_set_mesi    (oSetMesi),
        .o_done        (oDone)
`ifdef CACHE_STATS_EN
        ,
        .o_hit_cnt     (oHitCnt),
        .o_miss_cnt    (oMissCnt),
        .o_wb_cnt      (oWbCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] addr;
        logic        rd, wr, hit, ack;
        logic [4:0]  vtag;
        logic [1:0]  vmesi;
        logic        isIdle;
        logic [23:0] expOut;
        logic [9:0]  expFld;
    } vec_t;

    vec_t  vecs[$];
    string names[$];

    function automatic logic [23:0] packOut(input logic stall, modify, req, we,
                                            input logic [11:0] addr,
                                            input logic evict, refill,
                                            input logic [1:0] beat,
                                            input logic wetag,
                                            input logic [1:0] mesi,
                                            input logic done);
        return {stall, modify, req, we, addr, evict, refill, beat, wetag, mesi, done};
    endfunction

    function automatic vec_t idleVec(input logic [13:0] addr, input logic rd, wr, hit,
                                     input logic [4:0] vtag, input logic [1:0] vmesi,
                                     input logic expStall, expModify, input logic [9:0] fld);
        vec_t v;
        v.addr = addr; v.rd = rd; v.wr = wr; v.hit = hit; v.ack = 1'b0;
        v.vtag = vtag; v.vmesi = vmesi; v.isIdle = 1'b1;
        v.expOut = packOut(expStall, expModify, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        v.expFld = fld;
        return v;
    endfunction

    // Core-side inputs are deliberately junk here: the controller must ignore them mid-miss.
    function automatic vec_t memVec(input logic ack, we, input logic [11:0] mmAddr,
                                    input logic [1:0] beat, input logic [9:0] fld);
        vec_t v;
        v.addr = 14'h3FFF; v.rd = 1'b0; v.wr = 1'b1; v.hit = 1'b1; v.ack = ack;
        v.vtag = 5'h1F; v.vmesi = 2'b10; v.isIdle = 1'b0;
        v.expOut = packOut(1'b1, 1'b0, 1'b1, we, mmAddr, we, ~we & ack, beat, 1'b0, 2'd0, 1'b0);
        v.expFld = fld;
        return v;
    endfunction

    function automatic vec_t commitVec(input logic [1:0] mesi, input logic ack, input logic [9:0] fld);
        vec_t v;
        v.addr = 14'h3FFF; v.rd = 1'b1; v.wr = 1'b0; v.hit = 1'b0; v.ack = ack;
        v.vtag = 5'h1F; v.vmesi = 2'b10; v.isIdle = 1'b0;
        v.expOut = packOut(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 2'd0, 1'b1, mesi, 1'b1);
        v.expFld = fld;
        return v;
    endfunction

    task automatic addVec(input string name, input vec_t v);
        vecs.push_back(v);
        names.push_back(name);
    endtask

    task automatic driveInputs(input vec_t v);
        iAddr       = v.addr;
        iRd         = v.rd;
        iWr         = v.wr;
        iHit        = v.hit;
        iVictimTag  = v.vtag;
        iVictimMesi = v.vmesi;
        mm.mm_ack   = v.ack;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        logic [23:0] act;
        logic [9:0]  fld;
        act = packOut(oStall, oModify, mm.mm_req, mm.mm_we, mm.mm_addr, oEvictRd, oRefillWe,
                      oBeat, oWetag, oSetMesi, oDone);
        fld = {oTag, oIndex, oOffset};
        checks++;
        if (act !== v.expOut) begin
            fails++;
            $display("[TB] FAIL %s outputs: got %h expected %h", name, act, v.expOut);
        end
        checks++;
        if (fld !== v.expFld) begin
            fails++;
            $display("[TB] FAIL %s fields: got %h expected %h", name, fld, v.expFld);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk);
        driveInputs(v);
        #1;
        checkOutput(v, name);
        if (v.isIdle && (v.rd || v.wr)) begin
            if (v.hit) begin
                expHit++;
            end else begin
                expMiss++;
                if (v.vmesi == 2'b10) expWb++;
            end
        end
    endtask

    task automatic checkCounter(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;

        nrst = 1'b0;
        driveInputs(idleVec(14'h0, 1'b0, 1'b0, 1'b0, 5'h0, 2'b00, 1'b0, 1'b0, 10'h0));

        // Fields for 0x0124 = {tag 2, idx 2, off 1} = 0x049; 0x03A8 -> 0x0EA; 0x0FFC -> 0x3FF.
        addVec("reset_idle", idleVec(14'h0000, 0, 0, 0, 5'h00, 2'b00, 0, 0, 10'h000));
        addVec("rd_hit",     idleVec(14'h0124, 1, 0, 1, 5'h00, 2'b00, 0, 0, 10'h049));
        addVec("wr_hit",     idleVec(14'h0124, 0, 1, 1, 5'h00, 2'b00, 0, 1, 10'h049));
        addVec("rdwr_hit",   idleVec(14'h0124, 1, 1, 1, 5'h00, 2'b00, 0, 1, 10'h049));
        addVec("no_req",     idleVec(14'h0FFC, 0, 0, 0, 5'h1A, 2'b10, 0, 0, 10'h3FF));
        v = idleVec(14'h0FFC, 0, 0, 0, 5'h1A, 2'b10, 0, 0, 10'h3FF);
        v.ack = 1'b1;
        addVec("ack_in_idle", v);
        addVec("hi_bits_hit", idleVec(14'h3124, 1, 0, 1, 5'h00, 2'b00, 0, 0, 10'h049));

        addVec("clean_miss", idleVec(14'h0124, 1, 0, 0, 5'h05, 2'b11, 1, 0, 10'h049));
        for (int b = 0; b < 4; b++)
            addVec("clean_refill", memVec(1'b1, 1'b0, 12'(72 + b), 2'(b), 10'h049));
        addVec("clean_commit", commitVec(2'b11, 1'b0, 10'h049));
        addVec("clean_retry", idleVec(14'h0124, 1, 0, 1, 5'h00, 2'b00, 0, 0, 10'h049));

        addVec("dirty_miss", idleVec(14'h03A8, 0, 1, 0, 5'h1A, 2'b10, 1, 0, 10'h0EA));
        for (int b = 0; b < 4; b++)
            addVec("dirty_evict", memVec(1'b1, 1'b1, 12'(840 + b), 2'(b), 10'h0EA));
        for (int b = 0; b < 4; b++)
            addVec("dirty_refill", memVec(1'b1, 1'b0, 12'(232 + b), 2'(b), 10'h0EA));
        addVec("dirty_commit", commitVec(2'b10, 1'b1, 10'h0EA));
        addVec("dirty_retry", idleVec(14'h03A8, 0, 1, 1, 5'h00, 2'b00, 0, 1, 10'h0EA));

        addVec("slow_miss", idleVec(14'h0124, 1, 0, 0, 5'h0F, 2'b01, 1, 0, 10'h049));
        for (int b = 0; b < 4; b++) begin
            addVec("slow_wait1", memVec(1'b0, 1'b0, 12'(72 + b), 2'(b), 10'h049));
            addVec("slow_wait2", memVec(1'b0, 1'b0, 12'(72 + b), 2'(b), 10'h049));
            addVec("slow_ack",   memVec(1'b1, 1'b0, 12'(72 + b), 2'(b), 10'h049));
        end
        addVec("slow_commit", commitVec(2'b11, 1'b0, 10'h049));

        addVec("inv_miss", idleVec(14'h0FFC, 1, 0, 0, 5'h03, 2'b00, 1, 0, 10'h3FF));
        for (int b = 0; b < 4; b++)
            addVec("inv_refill", memVec(1'b1, 1'b0, 12'(1020 + b), 2'(b), 10'h3FF));
        addVec("inv_commit", commitVec(2'b11, 1'b0, 10'h3FF));
        addVec("inv_retry", idleVec(14'h0FFC, 1, 0, 1, 5'h00, 2'b00, 0, 0, 10'h3FF));

        repeat (2) @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], names[i]);

`ifdef CACHE_STATS_EN
        @(negedge clk);
        checkCounter("hit_cnt", oHitCnt, expHit);
        checkCounter("miss_cnt", oMissCnt, expMiss);
        checkCounter("wb_cnt", oWbCnt, expWb);
`endif

        // Asynchronous reset in the middle of a write-back, with an ack pending.
        applyStimulus(idleVec(14'h03A8, 0, 1, 0, 5'h1A, 2'b10, 1, 0, 10'h0EA), "rst_miss");
        applyStimulus(memVec(1'b1, 1'b1, 12'd840, 2'd0, 10'h0EA), "rst_evict0");
        applyStimulus(memVec(1'b1, 1'b1, 12'd841, 2'd1, 10'h0EA), "rst_evict1");
        @(negedge clk);
        v = memVec(1'b1, 1'b1, 12'd842, 2'd2, 10'h0EA);
        driveInputs(v);
        #1;
        checkOutput(v, "rst_evict2");
        #1;
        v = idleVec(14'h0000, 0, 0, 0, 5'h00, 2'b00, 0, 0, 10'h000);
        driveInputs(v);
        nrst = 1'b0;
        #1;
        checkOutput(v, "async_reset");
        expHit = 0;
        expMiss = 0;
        expWb = 0;
`ifdef CACHE_STATS_EN
        checkCounter("hit_cnt_rst", oHitCnt, 0);
        checkCounter("miss_cnt_rst", oMissCnt, 0);
        checkCounter("wb_cnt_rst", oWbCnt, 0);
`endif
        @(negedge clk);
        nrst = 1'b1;

        applyStimulus(idleVec(14'h03A8, 0, 1, 0, 5'h1A, 2'b10, 1, 0, 10'h0EA), "post_rst_miss");
        applyStimulus(memVec(1'b0, 1'b1, 12'd840, 2'd0, 10'h0EA), "post_rst_wait");
        for (int b = 0; b < 4; b++)
            applyStimulus(memVec(1'b1, 1'b1, 12'(840 + b), 2'(b), 10'h0EA), "post_rst_evict");
        for (int b = 0; b < 4; b++)
            applyStimulus(memVec(1'b1, 1'b0, 12'(232 + b), 2'(b), 10'h0EA), "post_rst_refill");
        applyStimulus(commitVec(2'b10, 1'b0, 10'h0EA), "post_rst_commit");
        applyStimulus(idleVec(14'h0124, 1, 0, 1, 5'h00, 2'b00, 0, 0, 10'h049), "post_rst_hit");

`ifdef CACHE_STATS_EN
        @(negedge clk);
        checkCounter("hit_cnt_end", oHitCnt, expHit);
        checkCounter("miss_cnt_end", oMissCnt, expMiss);
        checkCounter("wb_cnt_end", oWbCnt, expWb);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
